// File: rtl/cell_plotter.sv
// Cell-to-pixel expander for the 160x120 VGA adapter: buffers cell updates in a FIFO,
// paints each cell as a CELL_SIZE x CELL_SIZE square, and offers a full-screen clear.
module cell_plotter #(
  parameter int unsigned CELL_SIZE  = 4,
  parameter int unsigned GRID_W     = 40,
  parameter int unsigned GRID_H     = 30,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_x,
  input  logic [7:0] in_y,
  input  logic [2:0] in_color,
  input  logic       clear,
  output logic [7:0] out_x,
  output logic [6:0] out_y,
  output logic [2:0] out_color,
  output logic       plot,
  output logic       busy,
  output logic       overflow,
  output logic       range_err
);

  localparam int unsigned SHIFT = $clog2(CELL_SIZE);
  localparam int unsigned DW    = (SHIFT > 0) ? SHIFT : 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned SCR_W = 160;
  localparam int unsigned SCR_H = 120;

  localparam logic [DW-1:0] D_LAST = DW'(CELL_SIZE - 1);
  localparam logic [7:0]    X_LAST = 8'(SCR_W - 1);
  localparam logic [6:0]    Y_LAST = 7'(SCR_H - 1);

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] color;
  } cell_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLOT,
    S_CLEAR
  } state_t;

  state_t        state, state_n;
  cell_t         mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          clear_pending, clear_pending_n;
  cell_t         cur, cur_n;
  logic [DW-1:0] dx, dy, dx_n, dy_n;
  logic [7:0]    px, px_n;
  logic [6:0]    py, py_n;
  logic [7:0]    out_x_n;
  logic [6:0]    out_y_n;
  logic [2:0]    out_color_n;
  logic          plot_n;
  logic          pop, clear_take;
  logic          accept, in_range, push;

  function automatic logic [7:0] pix_x(input logic [7:0] c, input logic [DW-1:0] d);
    return 8'(c << SHIFT) + 8'(d);
  endfunction

  function automatic logic [6:0] pix_y(input logic [7:0] c, input logic [DW-1:0] d);
    return 7'(c << SHIFT) + 7'(d);
  endfunction

  assign in_ready = (count != CW'(FIFO_DEPTH));
  assign accept   = in_valid & in_ready;
  assign in_range = (in_x < 8'(GRID_W)) & (in_y < 8'(GRID_H));
  assign push     = accept & in_range;
  assign busy     = (state != S_IDLE) | (count != '0) | clear_pending;

  // A clear pulse arriving on the entry edge is kept so it is not lost.
  assign clear_pending_n = (clear_pending & ~clear_take) | clear;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next state, scan counters and next pixel values
  always_comb begin
    state_n     = state;
    cur_n       = cur;
    dx_n        = dx;
    dy_n        = dy;
    px_n        = px;
    py_n        = py;
    out_x_n     = out_x;
    out_y_n     = out_y;
    out_color_n = out_color;
    plot_n      = 1'b0;
    pop         = 1'b0;
    clear_take  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (clear_pending) begin
          state_n     = S_CLEAR;
          clear_take  = 1'b1;
          px_n        = '0;
          py_n        = '0;
          out_x_n     = '0;
          out_y_n     = '0;
          out_color_n = '0;
          plot_n      = 1'b1;
        end else if (count != '0) begin
          state_n     = S_PLOT;
          pop         = 1'b1;
          cur_n       = mem[rd_ptr];
          dx_n        = '0;
          dy_n        = '0;
          out_x_n     = pix_x(mem[rd_ptr].x, '0);
          out_y_n     = pix_y(mem[rd_ptr].y, '0);
          out_color_n = mem[rd_ptr].color;
          plot_n      = 1'b1;
        end
      end

      S_PLOT: begin
        if ((dx == D_LAST) && (dy == D_LAST)) begin
          state_n = S_IDLE;
        end else begin
          if (dx == D_LAST) begin
            dx_n = '0;
            dy_n = dy + DW'(1);
          end else begin
            dx_n = dx + DW'(1);
          end
          out_x_n     = pix_x(cur.x, dx_n);
          out_y_n     = pix_y(cur.y, dy_n);
          out_color_n = cur.color;
          plot_n      = 1'b1;
        end
      end

      S_CLEAR: begin
        if ((px == X_LAST) && (py == Y_LAST)) begin
          state_n = S_IDLE;
        end else begin
          if (px == X_LAST) begin
            px_n = '0;
            py_n = py + 7'd1;
          end else begin
            px_n = px + 8'd1;
          end
          out_x_n     = px_n;
          out_y_n     = py_n;
          out_color_n = '0;
          plot_n      = 1'b1;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // Datapath, FIFO control and sticky flags
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      clear_pending <= 1'b0;
      cur           <= '0;
      dx            <= '0;
      dy            <= '0;
      px            <= '0;
      py            <= '0;
      out_x         <= '0;
      out_y         <= '0;
      out_color     <= '0;
      plot          <= 1'b0;
      overflow      <= 1'b0;
      range_err     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      clear_pending <= clear_pending_n;
      cur           <= cur_n;
      dx            <= dx_n;
      dy            <= dy_n;
      px            <= px_n;
      py            <= py_n;
      out_x         <= out_x_n;
      out_y         <= out_y_n;
      out_color     <= out_color_n;
      plot          <= plot_n;
      if (in_valid & ~in_ready) overflow  <= 1'b1;
      if (accept & ~in_range)   range_err <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {in_x, in_y, in_color};
  end

endmodule

// File: doc/cell_plotter.md
# cell_plotter

Downstream stage of the Game-of-Life simulation core. It accepts cell-coordinate updates (cell x, cell y, colour), buffers them in a small FIFO, and expands each cell into a CELL_SIZE×CELL_SIZE square of pixel writes. The writes drive the x/y/colour/plot inputs of the 160x120 VGA adapter. It also provides a full-screen clear sequence, so the simulation core never has to produce pixel-level traffic.

## Interface
Parameters:
- CELL_SIZE, 4 — pixel edge length of one cell; power of two.
- GRID_W, 40 — cells per row; GRID_W*CELL_SIZE ≤ 160.
- GRID_H, 30 — cells per column; GRID_H*CELL_SIZE ≤ 120.
- FIFO_DEPTH, 16 — update buffer entries; power of two.

Ports:
- clock  in  1  system clock (CLOCK_50); all state changes on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  update present on in_x/in_y/in_color.
- in_ready  out  1  FIFO can accept; equals (fifo count != FIFO_DEPTH).
- in_x  in  8  cell column.
- in_y  in  8  cell row.
- in_color  in  3  cell colour (3'b111 alive, 3'b000 dead).
- clear  in  1  one-cycle request to blank the entire screen.
- out_x  out  8  pixel x to the VGA adapter.
- out_y  out  7  pixel y to the VGA adapter.
- out_color  out  3  pixel colour.
- plot  out  1  pixel write strobe; one pixel per high cycle.
- busy  out  1  high in PLOT or CLEAR, when the FIFO is non-empty, or when a clear is pending.
- overflow  out  1  sticky; set when in_valid=1 while in_ready=0.
- range_err  out  1  sticky; set when an update with in_x≥GRID_W or in_y≥GRID_H is accepted.

## Operation
- **Handshake:** a transfer occurs on an edge where in_valid & in_ready.
  - In-range updates are written to the FIFO.
  - Out-of-range updates are consumed but discarded, and range_err is set.
  - The FIFO accepts input in every state, including CLEAR.
- **FIFO:** circular buffer with read and write pointers and a count.
  - Push and pop on the same edge leave the count unchanged.
  - Push is impossible when full, because in_ready is low.
  - Pointers wrap modulo FIFO_DEPTH.
- **Clear request:** clear=1 sets clear_pending. It is cleared when CLEAR is entered. Repeated pulses before service coalesce into one clear.
- **FSM states:** IDLE, PLOT, CLEAR.
  - IDLE: if clear_pending, go to CLEAR with px=0, py=0. Else, if the FIFO is non-empty, pop the head into cx/cy/col, set dx=dy=0, go to PLOT. Else stay in IDLE. clear has priority over the FIFO.
  - PLOT: drive out_x=cx*CELL_SIZE+dx, out_y=cy*CELL_SIZE+dy, out_color=col, plot=1. dx increments fastest; at dx=CELL_SIZE-1, dx wraps to 0 and dy increments. After the pixel (CELL_SIZE-1, CELL_SIZE-1), return to IDLE.
  - CLEAR: drive out_x=px, out_y=py, out_color=0, plot=1. Scan in raster order, x fastest, 0..159 then 0..119. After (159,119), return to IDLE.
  - clear arriving during PLOT does not abort the current cell; it is served from IDLE.
- **Arithmetic:** multiplications are shifts by log2(CELL_SIZE). Results are truncated to 8 bits (x) and 7 bits (y), and are always in range given the parameter constraints.
- **Registered outputs:** out_x, out_y, out_color, plot, overflow and range_err are registered. In IDLE, plot=0 and out_x/out_y/out_color hold their last values.

## Timing
- **Reset:** reset_n=0 at an edge gives the following values from the next cycle.
  - state=IDLE, FIFO empty, clear_pending=0.
  - plot=0, out_x=0, out_y=0, out_color=0.
  - overflow=0, range_err=0, busy=0, in_ready=1.
  - Reset mid-PLOT or mid-CLEAR aborts immediately and the FIFO contents are lost.
- **Latency:** for an update accepted at edge E0 into an empty FIFO with the FSM in IDLE, the pop happens at E1. The first pixel (plot=1) is presented during the cycle after E1.
- **Cell duration:** each cell takes exactly CELL_SIZE² plot-high cycles (16 at default), then one IDLE cycle with plot=0 before the next pop.
- **Throughput:** CELL_SIZE²+1 cycles per cell.
- **Clear duration:** 19200 plot-high cycles, then one IDLE cycle.
- **Simultaneous clear and push:** the push is stored, and the clear is served first if the FSM is in IDLE.
- **Flags:** overflow and range_err are visible the cycle after the offending edge.

## Test plan
- **Reset values:** hold reset_n=0 for 2 cycles, then release. Expect plot=0, in_ready=1, busy=0, overflow=0, range_err=0, out_x=out_y=0.
- **Single cell:** push (x=2, y=3, colour=7). Expect 16 consecutive plot cycles covering x 8..11 and y 12..15, x fastest, colour 7. The first pixel appears 2 cycles after in_valid is sampled. Afterwards busy=0.
- **FIFO full and overflow:** push 17 updates back-to-back while a clear runs. After the 16th, expect in_ready=0. The 17th (in_valid=1) sets overflow=1. All 16 stored cells are later plotted in order, each taking 17 cycles.
- **Out-of-range:** push (x=40, y=0). Expect the update consumed, range_err=1, and no plot pulses.
- **Clear pending during PLOT:** pulse clear during cell pixel 5, with a second cell queued. Expect the first cell to finish all 16 pixels, then 19200 colour-0 pixels ending at (159,119), then the queued cell.
- **Reset mid-PLOT:** assert reset_n=0 at pixel 7 with 3 cells queued. Expect plot=0 the next cycle, the FIFO empty, and no further plots after release.
